uart_frame_decoder: RTL and testbench

// - Store-and-forward frame decoder directly downstream of the UART RX byte stream.
// - Hunts for SOF, reads a length byte, buffers the payload and checks an 8-bit sum checksum.
// - Good frames are replayed on an AXI-Stream master with tlast on the final payload byte.
// - Bad, oversize or zero-length frames are dropped and counted; nothing partial leaves the block.

---
 rtl/uart_frame_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// Store-and-forward SOF/LEN/payload/CHK frame decoder replayed on AXI-Stream.
// Optional inter-byte timeout: define FRAME_DECODER_TIMEOUT_EN.
module uart_frame_decoder #(
    parameter logic [7:0] SOF_BYTE     = 8'h7E,
    parameter int         MAX_PAYLOAD  = 64,
    parameter int         TIMEOUT_CLKS = 86800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] err_count
);

    localparam int PW = $clog2(MAX_PAYLOAD + 1);
    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_EMIT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      sum_q, sum_d;
    logic [PW-1:0]   len_q, len_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            s_tready_q, s_tready_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic [7:0]      m_tdata_q, m_tdata_d;
    logic            m_tlast_q, m_tlast_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [15:0]     err_count_q, err_count_d;

    logic [7:0]      buf_mem [2**AW];
    logic            buf_we;
    logic            in_fire;
    logic            out_fire;
    logic            timeout_hit;
    logic [7:0]      chk_sum;
    logic [PW-1:0]   wr_next;
    logic [PW-1:0]   rd_next;

    assign in_fire  = s_tvalid && s_tready_q;
    assign out_fire = m_tvalid_q && m_tready;
    assign chk_sum  = sum_q + s_tdata;
    assign wr_next  = wr_ptr_q + PW'(1);
    assign rd_next  = rd_ptr_q + PW'(1);

`ifdef FRAME_DECODER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          in_frame;

    assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD)
                   || (state_q == S_CHK);
    assign timeout_hit = in_frame && !in_fire
                      && (int'(idle_q) == TIMEOUT_CLKS - 1);
    assign idle_d = (in_frame && !in_fire && !timeout_hit)
                  ? idle_q + TW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = (TIMEOUT_CLKS < 0);
`endif

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        m_tvalid_d  = m_tvalid_q;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        buf_we      = 1'b0;

        unique case (state_q)
            S_HUNT: begin
                if (in_fire && s_tdata == SOF_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (in_fire) begin
                    sum_d    = s_tdata;
                    wr_ptr_d = '0;
                    if (s_tdata == 8'h00 || int'(s_tdata) > MAX_PAYLOAD) begin
                        frame_err_d = 1'b1;
                        state_d     = S_HUNT;
                    end else begin
                        len_d   = PW'(s_tdata);
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (in_fire) begin
                    buf_we   = 1'b1;
                    sum_d    = chk_sum;
                    wr_ptr_d = wr_next;
                    if (wr_next == len_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (in_fire) begin
                    if (chk_sum == 8'h00) begin
                        frame_ok_d = 1'b1;
                        rd_ptr_d   = '0;
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = buf_mem[0];
                        m_tlast_d  = (len_q == PW'(1));
                        state_d    = S_EMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_HUNT;
                    end
                end
            end
            S_EMIT: begin
                if (out_fire) begin
                    if (m_tlast_q) begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        state_d    = S_HUNT;
                    end else begin
                        // Prefetch keeps back-to-back transfers at one byte/clk
                        rd_ptr_d  = rd_next;
                        m_tdata_d = buf_mem[rd_next[AW-1:0]];
                        m_tlast_d = (rd_next == len_q - PW'(1));
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        if (timeout_hit) begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
        end

        err_count_d = err_count_q;
        if (frame_err_d && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
        end

        s_tready_d = (state_d != S_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            sum_q       <= '0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tlast_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            m_tlast_q   <= m_tlast_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_ptr_q[AW-1:0]] <= s_tdata;
        end
    end

    assign s_tready  = s_tready_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tdata   = m_tdata_q;
    assign m_tlast   = m_tlast_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed and randomized frame streams checked against a frame-level model.
module tb_uart_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] err_count;

    uart_frame_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rmode = 0;
    int ok_seen = 0;
    int err_seen = 0;
    int err_total = 0;

    logic [7:0] sent[$];
    logic [7:0] got[$];
    bit         got_last[$];
    int         got_cyc[$];
    logic [7:0] pl[$];
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    int         exp_ok;
    int         exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level parse of everything sent since the last scenario
    function automatic void model_run();
        int i;
        int n;
        int len;
        int s;
        exp_data.delete();
        exp_last.delete();
        exp_ok = 0;
        exp_err = 0;
        i = 0;
        n = sent.size();
        while (i < n) begin
            if (sent[i] != 8'h7E) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            len = int'(sent[i+1]);
            if (len == 0 || len > 64) begin
                exp_err++;
                i += 2;
                continue;
            end
            if (i + 2 + len >= n) break;
            s = len;
            for (int k = 0; k <= len; k++) s += int'(sent[i+2+k]);
            if (s % 256 == 0) begin
                exp_ok++;
                for (int k = 0; k < len; k++) begin
                    exp_data.push_back(sent[i+2+k]);
                    exp_last.push_back(k == len - 1);
                end
            end else begin
                exp_err++;
            end
            i += len + 3;
        end
    endfunction

    task automatic send(input logic [7:0] b);
        int w;
        s_tdata = b;
        s_tvalid = 1'b1;
        w = 0;
        while (!s_tready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!s_tready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed s_tready 0 expected 1");
        end
        @(negedge clk);
        sent.push_back(b);
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int corrupt);
        int s;
        s = pl.size();
        send(8'h7E);
        send(8'(pl.size()));
        foreach (pl[k]) begin
            send(pl[k]);
            s += int'(pl[k]);
        end
        send(8'((256 - (s % 256) + corrupt) % 256));
    endtask

    task automatic rand_payload(input int len);
        pl.delete();
        for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic drain();
        int w;
        w = 0;
        @(negedge clk);
        while ((m_tvalid || !s_tready) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed busy expected idle");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_scn();
        sent.delete();
        got.delete();
        got_last.delete();
        got_cyc.delete();
        ok_seen = 0;
        err_seen = 0;
    endtask

    task automatic check_scn(input string tag);
        int mism;
        int ne;
        model_run();
        chk({tag, "_nbytes"}, got.size(), exp_data.size());
        mism = 0;
        ne = (got.size() < exp_data.size()) ? got.size() : exp_data.size();
        for (int k = 0; k < ne; k++) begin
            if (got[k] !== exp_data[k] || got_last[k] !== exp_last[k]) mism++;
        end
        chk({tag, "_bytes"}, mism, 0);
        chk({tag, "_ok"}, ok_seen, exp_ok);
        chk({tag, "_err"}, err_seen, exp_err);
        err_total += exp_err;
        chk({tag, "_err_count"}, err_count,
            (err_total > 65535) ? 65535 : err_total);
        clear_scn();
    endtask

    // Output sink: drives m_tready, logs transfers, checks invariants
    initial begin : sink
        logic       stall;
        logic [7:0] hd;
        logic       hl;
        stall = 1'b0;
        hd = '0;
        hl = 1'b0;
        m_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (stall) begin
                    chk("stall_data", m_tdata, hd);
                    chk("stall_last", m_tlast, hl);
                end
                if (m_tvalid) chk("s_tready_in_emit", s_tready, 0);
                chk("ok_err_excl", frame_ok & frame_err, 0);
                if (frame_ok) ok_seen++;
                if (frame_err) err_seen++;
            end
            case (rmode)
                0: m_tready = 1'b1;
                1: m_tready = !m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            if (rst_n === 1'b1 && m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                got_last.push_back(m_tlast);
                got_cyc.push_back(cyc);
            end
            stall = (rst_n === 1'b1) && m_tvalid && !m_tready;
            hd = m_tdata;
            hl = m_tlast;
        end
    end

    initial begin
        int t;
        int len;
        rst_n = 1'b0;
        s_tdata = '0;
        s_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        clear_scn();

        // 3-byte frame, continuous ready
        rmode = 0;
        send(8'h7E);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h97);
        chk("t1_latency_tvalid", m_tvalid, 1);
        chk("t1_frame_ok", frame_ok, 1);
        drain();
        chk("t1_consec", (got_cyc.size() == 3) ? got_cyc[2] - got_cyc[0] : -1, 2);
        chk("t1_first", (got.size() > 0) ? got[0] : 8'h00, 8'h11);
        check_scn("t1");

        // Bad checksum then a good frame
        send(8'h7E);
        send(8'h02);
        send(8'hAA);
        send(8'hBB);
        send(8'h00);
        drain();
        chk("t2_no_out", got.size(), 0);
        chk("t2_err_count", err_count, 1);
        rand_payload(5);
        send_frame(0);
        drain();
        check_scn("t2");

        // Zero and oversize length
        send(8'h7E);
        send(8'h00);
        send(8'h7E);
        send(8'h41);
        drain();
        chk("t3_hunt_ready", s_tready, 1);
        rand_payload(2);
        send_frame(0);
        drain();
        check_scn("t3");

        // Leading junk, SOF value inside payload
        send(8'h55);
        send(8'h7E);
        send(8'h01);
        send(8'h7E);
        send(8'h81);
        drain();
        check_scn("t4");

        // Full-size frame against a toggling sink
        rmode = 1;
        rand_payload(64);
        send_frame(0);
        drain();
        check_scn("t5");

        // Reset in the middle of a payload
        rmode = 0;
        send(8'h7E);
        send(8'h05);
        send(8'h01);
        send(8'h02);
        rst_n = 1'b0;
        #1;
        chk("t6_s_tready", s_tready, 0);
        chk("t6_m_tvalid", m_tvalid, 0);
        chk("t6_m_tdata", m_tdata, 0);
        chk("t6_err_count", err_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_scn();
        err_total = 0;
        rand_payload(4);
        send_frame(0);
        drain();
        check_scn("t6");

        // Randomized mix of frame kinds against a random sink
        rmode = 2;
        for (int f = 0; f < 40; f++) begin
            t = $urandom_range(0, 5);
            if (t <= 2) begin
                rand_payload($urandom_range(1, 64));
                send_frame(0);
            end else if (t == 3) begin
                rand_payload($urandom_range(1, 64));
                send_frame($urandom_range(1, 255));
            end else if (t == 4) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 255);
                send(8'h7E);
                send(8'(len));
            end else begin
                len = $urandom_range(0, 254);
                send(8'((len >= 126) ? len + 1 : len));
            end
        end
        drain();
        check_scn("rnd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
